// File: rtl/bu2020_pkg.sv
// Shared types and constants for the BU2020 5-stage 16-bit pipeline.
package bu2020_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  // Control-bit positions inside the pipeline registers
  localparam int WB_REGWRITE  = 0;
  localparam int WB_MEMTOREG  = 1;
  localparam int MEM_JUMP     = 0;
  localparam int MEM_BNE      = 1;
  localparam int MEM_MEMWRITE = 2;

endpackage

// File: rtl/raw_cmp.sv
// Compares one ID source register against the EX/MEM/WB writers.
module raw_cmp
  import bu2020_pkg::*;
#(
  parameter int WB_BYPASS = 0
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  logic                  ex_wr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  match
);

  logic wb_hit;

  // With write-before-read in the register file, WB results are visible to ID.
  assign wb_hit = (WB_BYPASS == 0) && wb_wr && (wb_rd == rs);

  assign match = use_rs && ((ex_wr && (ex_rd == rs)) ||
                            (mem_wr && (mem_rd == rs)) ||
                            wb_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencing for the BU2020 pipeline (no forwarding paths).
//   state  | meaning
//   RUN    | normal issue; stalls on RAW, redirects on taken branch
//   DRAIN  | HALT seen in ID; retiring EX/MEM/WB
//   HALTED | pipeline empty, waiting for resume
module pipeline_hazard_ctrl
  import bu2020_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WB_BYPASS    = 0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_halt,
  input  logic                  ex_wr,
  input  logic                  mem_wr,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_branch_taken,
  input  logic [DATA_W-1:0]     mem_target,
  input  logic                  resume,
  input  logic                  clear_cnt,
  output logic                  pc_write,
  output logic                  pc_sel,
  output logic [DATA_W-1:0]     pc_target,
  output logic                  if_id_write,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       match1, match2, raw_hazard, halt_req;
  logic       stall_inc, flush_inc;

  raw_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs1 (
    .rs(id_rs1), .use_rs(id_use_rs1),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .match(match1)
  );

  raw_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs2 (
    .rs(id_rs2), .use_rs(id_use_rs2),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .match(match2)
  );

  assign raw_hazard = id_valid && (match1 || match2);
  assign halt_req   = id_valid && id_is_halt;
  assign pc_target  = mem_target;
  assign halted     = (state_q == HALTED);

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_write  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_branch_taken) begin
          pc_sel       = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_inc    = 1'b1;
        end else if (raw_hazard) begin
          flush_id_ex = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_req) begin
          flush_id_ex = 1'b1;
          drain_d     = DRAIN_LOAD;
          state_d     = DRAIN;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      DRAIN: begin
        // A taken branch ahead of the HALT squashes it; abandon the drain.
        if (mem_branch_taken) begin
          pc_sel       = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_inc    = 1'b1;
          drain_d      = 2'd0;
          state_d      = RUN;
        end else begin
          flush_id_ex = 1'b1;
          if (drain_q == 2'd0) state_d = HALTED;
          else                 drain_d = drain_q - 2'd1;
        end
      end
      HALTED: begin
        flush_id_ex = 1'b1;
        if (resume) begin
          flush_if_id = 1'b1;
          pc_write    = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      if_id_write  = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clear_cnt) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: main, WB-bypass and 2-bit-counter variants.
module tb_pipeline_hazard_ctrl;
  import bu2020_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_is_halt;
  logic [2:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_wr, mem_wr, wb_wr, mem_branch_taken, resume, clear_cnt;
  logic [15:0] mem_target;

  logic pc_write, pc_sel, if_id_write, flush_if_id, flush_id_ex, flush_ex_mem, halted;
  logic [15:0] pc_target, stall_count, flush_count;

  logic b_pc_write, b_pc_sel, b_if_id_write, b_flush_if_id, b_flush_id_ex, b_flush_ex_mem, b_halted;
  logic [15:0] b_pc_target, b_stall_count, b_flush_count;

  logic s_pc_write, s_pc_sel, s_if_id_write, s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_halted;
  logic [15:0] s_pc_target;
  logic [1:0] s_stall_count, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .WB_BYPASS(0), .DRAIN_CYCLES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_halt(id_is_halt),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_branch_taken(mem_branch_taken), .mem_target(mem_target), .resume(resume),
    .clear_cnt(clear_cnt), .pc_write(pc_write), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_write(if_id_write), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .halted(halted), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(16), .WB_BYPASS(1), .DRAIN_CYCLES(3)) u_byp (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_halt(id_is_halt),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_branch_taken(mem_branch_taken), .mem_target(mem_target), .resume(resume),
    .clear_cnt(clear_cnt), .pc_write(b_pc_write), .pc_sel(b_pc_sel), .pc_target(b_pc_target),
    .if_id_write(b_if_id_write), .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex),
    .flush_ex_mem(b_flush_ex_mem), .halted(b_halted), .stall_count(b_stall_count),
    .flush_count(b_flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .WB_BYPASS(0), .DRAIN_CYCLES(3)) u_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_halt(id_is_halt),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_branch_taken(mem_branch_taken), .mem_target(mem_target), .resume(resume),
    .clear_cnt(clear_cnt), .pc_write(s_pc_write), .pc_sel(s_pc_sel), .pc_target(s_pc_target),
    .if_id_write(s_if_id_write), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .flush_ex_mem(s_flush_ex_mem), .halted(s_halted), .stall_count(s_stall_count),
    .flush_count(s_flush_count)
  );

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_halt = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_wr = 0; mem_wr = 0; wb_wr = 0; mem_branch_taken = 0; mem_target = 0;
    resume = 0; clear_cnt = 0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    #12;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got=%b exp=0", pc_write); end
    checks++; if (if_id_write !== 1'b0) begin errors++; $display("FAIL reset_if_id_write got=%b exp=0", if_id_write); end
    checks++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++; $display("FAIL reset_flushes got=%b exp=111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
    checks++; if (pc_sel !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_sel_halted got=%b%b exp=00", pc_sel, halted); end
    checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
    @(posedge clk); #3; rst_n = 1; #1;
    checks++; if (pc_write !== 1'b1 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL post_reset_run got pc_write=%b flush_id_ex=%b exp=1/0", pc_write, flush_id_ex); end
    cyc();
  endtask

  task automatic test_independent();
    idle();
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
    ex_wr = 1; ex_rd = 3; mem_wr = 1; mem_rd = 4; wb_wr = 1; wb_rd = 5;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (pc_write !== 1'b1 || if_id_write !== 1'b1 || {flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b000)
        begin errors++; $display("FAIL indep_cycle%0d got pc_write=%b if_id_write=%b flushes=%b exp=1/1/000", i, pc_write, if_id_write, {flush_if_id, flush_id_ex, flush_ex_mem}); end
      cyc();
    end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL indep_stall_count got=%0d exp=0", stall_count); end
    idle();
  endtask

  task automatic test_raw();
    logic [2:0] exp_main, exp_byp;
    idle();
    id_valid = 1; id_rs1 = 3; id_use_rs1 = 1;
    // writer in EX, MEM, WB, then gone
    exp_main = 3'b111; exp_byp = 3'b110;
    for (int s = 0; s < 4; s++) begin
      ex_wr = (s == 0); mem_wr = (s == 1); wb_wr = (s == 2);
      ex_rd = 3; mem_rd = 3; wb_rd = 3;
      #1;
      if (s < 3) begin
        checks++; if (flush_id_ex !== exp_main[2-s] || pc_write !== !exp_main[2-s]) begin errors++; $display("FAIL raw_main_stage%0d got flush_id_ex=%b pc_write=%b exp stall=%b", s, flush_id_ex, pc_write, exp_main[2-s]); end
        checks++; if (b_flush_id_ex !== exp_byp[2-s] || b_pc_write !== !exp_byp[2-s]) begin errors++; $display("FAIL raw_byp_stage%0d got flush_id_ex=%b pc_write=%b exp stall=%b", s, b_flush_id_ex, b_pc_write, exp_byp[2-s]); end
      end else begin
        checks++; if (pc_write !== 1'b1 || b_pc_write !== 1'b1 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL raw_release got pc_write=%b/%b flush_id_ex=%b exp=1/1/0", pc_write, b_pc_write, flush_id_ex); end
      end
      cyc();
    end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL raw_stall_count_main got=%0d exp=3", stall_count); end
    checks++; if (b_stall_count !== 16'd2) begin errors++; $display("FAIL raw_stall_count_byp got=%0d exp=2", b_stall_count); end
    idle();
  endtask

  task automatic test_branch();
    idle();
    id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; ex_wr = 1; ex_rd = 3;
    mem_branch_taken = 1; mem_target = 16'h0040;
    #1;
    checks++; if (pc_sel !== 1'b1 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin errors++; $display("FAIL branch_pc got sel=%b write=%b if_id=%b exp=111", pc_sel, pc_write, if_id_write); end
    checks++; if (pc_target !== 16'h0040) begin errors++; $display("FAIL branch_target got=%h exp=0040", pc_target); end
    checks++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++; $display("FAIL branch_flushes got=%b exp=111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
    cyc();
    idle();
    #1;
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL branch_flush_count got=%0d exp=1", flush_count); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL branch_stall_unchanged got=%0d exp=3", stall_count); end
    checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL branch_one_cycle got pc_sel=%b exp=0", pc_sel); end
    cyc();
  endtask

  task automatic test_halt();
    idle();
    resume = 1; #1;
    checks++; if (flush_if_id !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL resume_in_run_ignored got flush_if_id=%b pc_write=%b exp=0/1", flush_if_id, pc_write); end
    cyc();
    idle();
    id_valid = 1; id_is_halt = 1; #1;
    checks++; if (pc_write !== 1'b0 || flush_id_ex !== 1'b1 || if_id_write !== 1'b0) begin errors++; $display("FAIL halt_issue got pc_write=%b flush_id_ex=%b if_id=%b exp=0/1/0", pc_write, flush_id_ex, if_id_write); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if (halted !== 1'b0 || pc_write !== 1'b0 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL drain_cycle%0d got halted=%b pc_write=%b flush_id_ex=%b exp=0/0/1", i, halted, pc_write, flush_id_ex); end
      cyc();
    end
    id_valid = 0; id_is_halt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (halted !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL halted_hold%0d got halted=%b pc_write=%b exp=1/0", i, halted, pc_write); end
      cyc();
    end
    resume = 1; #1;
    checks++; if (flush_if_id !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL resume_cycle got flush_if_id=%b pc_write=%b exp=1/1", flush_if_id, pc_write); end
    cyc();
    resume = 0; #1;
    checks++; if (halted !== 1'b0 || pc_write !== 1'b1 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL after_resume got halted=%b pc_write=%b flush_id_ex=%b exp=0/1/0", halted, pc_write, flush_id_ex); end
    cyc();
  endtask

  task automatic test_drain_branch();
    idle();
    id_valid = 1; id_is_halt = 1;
    cyc();   // now DRAIN, counter 2
    cyc();   // counter 1
    mem_branch_taken = 1; mem_target = 16'h1234; #1;
    checks++; if (pc_sel !== 1'b1 || pc_target !== 16'h1234 || flush_ex_mem !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL drain_branch got sel=%b target=%h flush_ex_mem=%b halted=%b exp=1/1234/1/0", pc_sel, pc_target, flush_ex_mem, halted); end
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (halted !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL drain_branch_run%0d got halted=%b pc_write=%b exp=0/1", i, halted, pc_write); end
      cyc();
    end
    checks++; if (flush_count !== 16'd2) begin errors++; $display("FAIL drain_branch_flush_count got=%0d exp=2", flush_count); end
  endtask

  task automatic test_saturation();
    idle();
    clear_cnt = 1;
    cyc();
    clear_cnt = 0;
    checks++; if (s_stall_count !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL clear_cnt got small=%0d main=%0d flush=%0d exp=0/0/0", s_stall_count, stall_count, flush_count); end
    id_valid = 1; id_rs2 = 6; id_use_rs2 = 1; mem_wr = 1; mem_rd = 6;
    cyc(); cyc();
    checks++; if (s_stall_count !== 2'd2) begin errors++; $display("FAIL sat_pre got=%0d exp=2", s_stall_count); end
    cyc(); cyc(); cyc();
    checks++; if (s_stall_count !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", s_stall_count); end
    checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL sat_main_count got=%0d exp=5", stall_count); end
    clear_cnt = 1;
    cyc();
    clear_cnt = 0;
    checks++; if (s_stall_count !== 2'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL clear_beats_inc got small=%0d main=%0d exp=0/0", s_stall_count, stall_count); end
    idle();
    cyc();
  endtask

  task automatic test_async_reset();
    idle();
    id_valid = 1; id_is_halt = 1;
    cyc(); idle();
    cyc(); cyc(); cyc();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL async_pre_halted got=%b exp=1", halted); end
    #2; rst_n = 0; #1;
    checks++; if (halted !== 1'b0 || flush_if_id !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL async_reset got halted=%b flush_if_id=%b pc_write=%b exp=0/1/0", halted, flush_if_id, pc_write); end
    #1; rst_n = 1;
    cyc();
    checks++; if (halted !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL async_release_run got halted=%b pc_write=%b exp=0/1", halted, pc_write); end
  endtask

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_branch();
    test_halt();
    test_drain_branch();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
